// File: rtl/dm_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port, 1-cycle-read data memory.
// Grants are combinational; commands are registered onto the DM port and read data is tagged with the issuer.
module dm_port_arbiter #(
    parameter int AW  = 14,
    parameter int DW  = 32,
    parameter int OPW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           bist_mode_i,

    input  logic           req0_valid_i,
    output logic           req0_ready_o,
    input  logic           req0_wen_i,
    input  logic [AW-1:0]  req0_addr_i,
    input  logic [DW-1:0]  req0_data_i,
    input  logic [OPW-1:0] req0_dopc_i,

    input  logic           req1_valid_i,
    output logic           req1_ready_o,
    input  logic           req1_wen_i,
    input  logic [AW-1:0]  req1_addr_i,
    input  logic [DW-1:0]  req1_data_i,
    input  logic [OPW-1:0] req1_dopc_i,

    output logic [AW-1:0]  dm_addr_o,
    output logic [DW-1:0]  dm_data_o,
    output logic           dm_wen_o,
    output logic [OPW-1:0] dm_dopc_o,
    output logic           dm_req_o,
    input  logic [DW-1:0]  dm_data_i,

    output logic           rsp_valid_o,
    output logic           rsp_id_o,
    output logic [DW-1:0]  rsp_data_o,
    output logic           busy_o
);

    logic           r_ptr;
    logic           w_grant0;
    logic           w_grant1;
    logic           w_hs;

    logic           r_req_p1;
    logic           r_wen_p1;
    logic           r_id_p1;
    logic [AW-1:0]  r_addr_p1;
    logic [DW-1:0]  r_data_p1;
    logic [OPW-1:0] r_dopc_p1;

    logic           r_vld_p2;
    logic           r_id_p2;

    // Arbitration: the pointer side wins a tie; BIST blocks every grant
    always_comb begin
        w_grant0 = !bist_mode_i && req0_valid_i && (!req1_valid_i || !r_ptr);
        w_grant1 = !bist_mode_i && req1_valid_i && (!req0_valid_i ||  r_ptr);
        w_hs     = w_grant0 || w_grant1;
    end

    assign req0_ready_o = w_grant0;
    assign req1_ready_o = w_grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_hs) begin
            r_ptr <= w_grant0;
        end
    end

    // Issue stage: command on the DM port; payload holds when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_p1  <= 1'b0;
            r_wen_p1  <= 1'b0;
            r_id_p1   <= 1'b0;
            r_addr_p1 <= '0;
            r_data_p1 <= '0;
            r_dopc_p1 <= '0;
        end else if (w_hs) begin
            r_req_p1  <= 1'b1;
            r_id_p1   <= w_grant1;
            r_wen_p1  <= w_grant1 ? req1_wen_i  : req0_wen_i;
            r_addr_p1 <= w_grant1 ? req1_addr_i : req0_addr_i;
            r_data_p1 <= w_grant1 ? req1_data_i : req0_data_i;
            r_dopc_p1 <= w_grant1 ? req1_dopc_i : req0_dopc_i;
        end else begin
            r_req_p1  <= 1'b0;
            r_wen_p1  <= 1'b0;
        end
    end

    // Response stage: only reads come back, one cycle after the DM saw them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2 <= 1'b0;
            r_id_p2  <= 1'b0;
        end else begin
            r_vld_p2 <= r_req_p1 && !r_wen_p1;
            r_id_p2  <= r_id_p1;
        end
    end

    assign dm_addr_o   = r_addr_p1;
    assign dm_data_o   = r_data_p1;
    assign dm_wen_o    = r_wen_p1;
    assign dm_dopc_o   = r_dopc_p1;
    assign dm_req_o    = r_req_p1;

    assign rsp_valid_o = r_vld_p2;
    assign rsp_id_o    = r_id_p2;
    assign rsp_data_o  = dm_data_i;
    assign busy_o      = r_req_p1 || r_vld_p2;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural 1-cycle-read DM model.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bist = 1'b0;
    logic        v0 = 1'b0, w0 = 1'b0, v1 = 1'b0, w1 = 1'b0;
    logic [13:0] a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic        rdy0, rdy1;
    logic [13:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_wen, dm_req;
    logic [1:0]  dm_dopc;
    logic [31:0] dm_rdata;
    logic        rsp_valid, rsp_id, busy;
    logic [31:0] rsp_data;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.AW(14), .DW(32), .OPW(2)) dut (
        .clk(clk), .rst(rst), .bist_mode_i(bist),
        .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_wen_i(w0),
        .req0_addr_i(a0), .req0_data_i(d0), .req0_dopc_i(2'b01),
        .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_wen_i(w1),
        .req1_addr_i(a1), .req1_data_i(d1), .req1_dopc_i(2'b10),
        .dm_addr_o(dm_addr), .dm_data_o(dm_wdata), .dm_wen_o(dm_wen),
        .dm_dopc_o(dm_dopc), .dm_req_o(dm_req), .dm_data_i(dm_rdata),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
        .busy_o(busy)
    );

    // DM model: unwritten words read as 0xA5A50000 | addr
    bit [31:0] mem [16384];
    bit        written [16384];
    always @(posedge clk) begin
        if (dm_req) begin
            if (dm_wen) begin
                mem[dm_addr]     <= dm_wdata;
                written[dm_addr] <= 1'b1;
            end else begin
                dm_rdata <= written[dm_addr] ? mem[dm_addr] : (32'hA5A50000 | {18'd0, dm_addr});
            end
        end
    end

    typedef struct {
        logic        bist;
        logic        v0, w0;
        logic [13:0] a0;
        logic [31:0] d0;
        logic        v1, w1;
        logic [13:0] a1;
        logic [31:0] d1;
        logic        e_rdy0, e_rdy1, e_req, e_wen;
        logic [13:0] e_addr;
        logic        e_rsp, e_id;
        logic [31:0] e_data;
        logic        e_busy;
    } vec_t;

    vec_t tv [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bist = 1'b0; v0 = 1'b0; w0 = 1'b0; v1 = 1'b0; w1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    int h0, h1;

    initial begin
        tv[0]  = '{0, 0,0,14'h0000,32'h0,        0,0,14'h0000,32'h0,        0,0,0,0,14'h0000, 0,0,32'h0,        0};
        tv[1]  = '{0, 1,1,14'h0010,32'hDEADBEEF, 0,0,14'h0000,32'h0,        1,0,0,0,14'h0000, 0,0,32'h0,        0};
        tv[2]  = '{0, 1,0,14'h0010,32'h0,        0,0,14'h0000,32'h0,        1,0,1,1,14'h0010, 0,0,32'h0,        1};
        tv[3]  = '{0, 0,0,14'h0000,32'h0,        0,0,14'h0000,32'h0,        0,0,1,0,14'h0010, 0,0,32'h0,        1};
        tv[4]  = '{0, 0,0,14'h0000,32'h0,        0,0,14'h0000,32'h0,        0,0,0,0,14'h0010, 1,0,32'hDEADBEEF, 1};
        tv[5]  = '{0, 0,0,14'h0000,32'h0,        0,0,14'h0000,32'h0,        0,0,0,0,14'h0010, 0,0,32'h0,        0};
        tv[6]  = '{0, 1,1,14'h0020,32'h11111111, 1,1,14'h0021,32'h22222222, 0,1,0,0,14'h0010, 0,0,32'h0,        0};
        tv[7]  = '{0, 1,1,14'h0020,32'h11111111, 1,0,14'h0020,32'h0,        1,0,1,1,14'h0021, 0,0,32'h0,        1};
        tv[8]  = '{0, 0,0,14'h0000,32'h0,        1,0,14'h0020,32'h0,        0,1,1,1,14'h0020, 0,0,32'h0,        1};
        tv[9]  = '{0, 0,0,14'h0000,32'h0,        0,0,14'h0000,32'h0,        0,0,1,0,14'h0020, 0,0,32'h0,        1};
        tv[10] = '{0, 0,0,14'h0000,32'h0,        0,0,14'h0000,32'h0,        0,0,0,0,14'h0020, 1,1,32'h11111111, 1};
        tv[11] = '{0, 0,0,14'h0000,32'h0,        0,0,14'h0000,32'h0,        0,0,0,0,14'h0020, 0,0,32'h0,        0};
        tv[12] = '{1, 1,0,14'h3FFF,32'h0,        1,0,14'h0010,32'h0,        0,0,0,0,14'h0020, 0,0,32'h0,        0};
        tv[13] = '{0, 1,0,14'h3FFF,32'h0,        1,0,14'h0010,32'h0,        1,0,0,0,14'h0020, 0,0,32'h0,        0};
        tv[14] = '{0, 0,0,14'h0000,32'h0,        1,0,14'h0010,32'h0,        0,1,1,0,14'h3FFF, 0,0,32'h0,        1};
        tv[15] = '{0, 0,0,14'h0000,32'h0,        0,0,14'h0000,32'h0,        0,0,1,0,14'h0010, 1,0,32'hA5A53FFF, 1};
        tv[16] = '{0, 0,0,14'h0000,32'h0,        0,0,14'h0000,32'h0,        0,0,0,0,14'h0010, 1,1,32'hDEADBEEF, 1};
        tv[17] = '{0, 0,0,14'h0000,32'h0,        0,0,14'h0000,32'h0,        0,0,0,0,14'h0010, 0,0,32'h0,        0};

        // Reset state
        cyc();
        chk("rst dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst dm_wen", {31'd0, dm_wen}, 32'd0);
        chk("rst dm_addr", {18'd0, dm_addr}, 32'd0);
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Table: inputs driven after the edge, every output compared in the same cycle
        for (int i = 0; i < 18; i++) begin
            cyc();
            bist = tv[i].bist;
            v0 = tv[i].v0; w0 = tv[i].w0; a0 = tv[i].a0; d0 = tv[i].d0;
            v1 = tv[i].v1; w1 = tv[i].w1; a1 = tv[i].a1; d1 = tv[i].d1;
            #1;
            chk($sformatf("row%0d rdy0", i), {31'd0, rdy0}, {31'd0, tv[i].e_rdy0});
            chk($sformatf("row%0d rdy1", i), {31'd0, rdy1}, {31'd0, tv[i].e_rdy1});
            chk($sformatf("row%0d dm_req", i), {31'd0, dm_req}, {31'd0, tv[i].e_req});
            chk($sformatf("row%0d dm_wen", i), {31'd0, dm_wen}, {31'd0, tv[i].e_wen});
            chk($sformatf("row%0d dm_addr", i), {18'd0, dm_addr}, {18'd0, tv[i].e_addr});
            chk($sformatf("row%0d rsp_valid", i), {31'd0, rsp_valid}, {31'd0, tv[i].e_rsp});
            chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, tv[i].e_busy});
            if (tv[i].e_rsp) begin
                chk($sformatf("row%0d rsp_id", i), {31'd0, rsp_id}, {31'd0, tv[i].e_id});
                chk($sformatf("row%0d rsp_data", i), rsp_data, tv[i].e_data);
            end
        end

        // T2: both valid for 8 cycles straight after reset
        do_reset();
        h0 = 0; h1 = 0;
        v0 = 1'b1; a0 = 14'h0100;
        v1 = 1'b1; a1 = 14'h0200;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t2 c%0d rdy0", i), {31'd0, rdy0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t2 c%0d rdy1", i), {31'd0, rdy1}, (i % 2 == 1) ? 32'd1 : 32'd0);
            h0 += int'(rdy0);
            h1 += int'(rdy1);
            cyc();
        end
        chk("t2 hs0 count", h0, 32'd4);
        chk("t2 hs1 count", h1, 32'd4);

        // T3: req1 alone three times, then a tie goes to req0
        do_reset();
        v1 = 1'b1; a1 = 14'h0300;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t3 solo%0d rdy1", i), {31'd0, rdy1}, 32'd1);
            cyc();
        end
        v0 = 1'b1; a0 = 14'h0301;
        #1;
        chk("t3 tie rdy0", {31'd0, rdy0}, 32'd1);
        chk("t3 tie rdy1", {31'd0, rdy1}, 32'd0);

        // T4: four reads at one per clock to the top of the address space
        do_reset();
        cyc();
        for (int j = 0; j < 6; j++) begin
            idle();
            if (j < 4) begin
                if (j % 2 == 0) begin
                    v0 = 1'b1; a0 = 14'h3FFC + 14'(j);
                end else begin
                    v1 = 1'b1; a1 = 14'h3FFC + 14'(j);
                end
            end
            #1;
            if (j >= 1 && j <= 4)
                chk($sformatf("t4 dm_addr%0d", j - 1), {18'd0, dm_addr}, 32'h3FFC + (j - 1));
            if (j >= 2) begin
                chk($sformatf("t4 rsp_valid%0d", j - 2), {31'd0, rsp_valid}, 32'd1);
                chk($sformatf("t4 rsp_id%0d", j - 2), {31'd0, rsp_id}, (j % 2 == 1) ? 32'd1 : 32'd0);
                chk($sformatf("t4 rsp_data%0d", j - 2), rsp_data, 32'hA5A53FFC + (j - 2));
            end
            cyc();
        end
        idle();
        #1;
        chk("t4 rsp after stream", {31'd0, rsp_valid}, 32'd0);

        // T5: BIST rises right after a read is accepted
        do_reset();
        v0 = 1'b1; a0 = 14'h0005;
        #1;
        chk("t5 accept rdy0", {31'd0, rdy0}, 32'd1);
        cyc();
        bist = 1'b1; v0 = 1'b1; v1 = 1'b1; a0 = 14'h0006; a1 = 14'h0007;
        #1;
        chk("t5 bist rdy0", {31'd0, rdy0}, 32'd0);
        chk("t5 bist rdy1", {31'd0, rdy1}, 32'd0);
        chk("t5 issue dm_req", {31'd0, dm_req}, 32'd1);
        cyc();
        #1;
        chk("t5 rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t5 rsp_data", rsp_data, 32'hA5A50005);
        chk("t5 busy draining", {31'd0, busy}, 32'd1);
        chk("t5 bist rdy0 b", {31'd0, rdy0}, 32'd0);
        cyc();
        #1;
        chk("t5 busy drained", {31'd0, busy}, 32'd0);
        chk("t5 dm_req idle", {31'd0, dm_req}, 32'd0);
        chk("t5 bist rdy1 c", {31'd0, rdy1}, 32'd0);

        // T6: async reset with two reads in flight; pointer must return to req0
        do_reset();
        v1 = 1'b1; a1 = 14'h0040;
        #1;
        chk("t6 accept rdy1", {31'd0, rdy1}, 32'd1);
        cyc();
        idle();
        v0 = 1'b1; a0 = 14'h0041;
        #1;
        chk("t6 accept rdy0", {31'd0, rdy0}, 32'd1);
        cyc();
        idle();
        #1;
        chk("t6 pre dm_req", {31'd0, dm_req}, 32'd1);
        chk("t6 pre rsp_valid", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6 rst dm_req", {31'd0, dm_req}, 32'd0);
        chk("t6 rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6 rst busy", {31'd0, busy}, 32'd0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("t6 post rsp%0d", i), {31'd0, rsp_valid}, 32'd0);
        end
        v0 = 1'b1; v1 = 1'b1;
        #1;
        chk("t6 ptr rdy0", {31'd0, rdy0}, 32'd1);
        chk("t6 ptr rdy1", {31'd0, rdy1}, 32'd0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
